// File: rtl/seed_drop_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// seed_seq_pkg
// Shared definitions for the seed drop sequencer:
//   - seq_state_e         : 3-bit FSM state encoding (IDLE..FAULT)
//   - drop_timeout_cycles : converts a clock frequency and a millisecond
//                           timeout into a clock-cycle count
// ---------------------------------------------------------------------------
package seed_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_METER  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CLOSE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_FAULT  = 3'd6
  } seq_state_e;

  // Metering timeout expressed in clock cycles.
  function automatic logic [31:0] drop_timeout_cycles(input int unsigned clock_freq,
                                                      input int unsigned timeout_ms);
    return 32'((clock_freq / 32'd1000) * timeout_ms);
  endfunction

endpackage

// File: rtl/seed_drop_sequencer_timer.sv
// ---------------------------------------------------------------------------
// seq_timer
// Loadable 32-bit down counter with a terminal-count flag. Shared by the
// metering timeout and the settle wait.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_val (takes precedence over run)
//   run         : decrement by one per cycle, holding at zero
//   load_val    : value to load
//   expired     : count has reached zero
// ---------------------------------------------------------------------------
module seq_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        run,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (run && (count_q != 32'd0)) begin
      count_d = count_q - 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 32'd0);

endmodule

// File: rtl/seed_drop_sequencer.sv
// ---------------------------------------------------------------------------
// seed_drop_sequencer
// Per-hole controller: opens a counting window, runs the metering motor until
// the counter reports its target or a timeout expires, lets seeds settle and
// closes the window. Reports completion, short holes and sensor faults.
//
// Optional feature macro: SEQ_RETRY_EN -- on a metering timeout, retry up to
// MAX_RETRIES extra times before declaring a short hole.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : sequencer enable; low in FAULT clears the fault
//   hole_ready        : pulse, robot positioned over a hole
//   abort             : terminate the current hole immediately
//   target_reached    : counter reached its target
//   sensor_error      : counter sensor fault
//   start_counting    : 1-cycle pulse, open counting window
//   stop_counting     : 1-cycle pulse, close counting window
//   meter_motor_on    : metering motor drive (gated off by abort)
//   busy              : not IDLE
//   hole_done         : 1-cycle pulse, hole completed
//   hole_short        : with hole_done, target not reached
//   hole_aborted      : 1-cycle pulse, hole ended via abort
//   fault             : in FAULT
//   state             : current state encoding
//   short_hole_count  : saturating short-hole counter
// ---------------------------------------------------------------------------
module seed_drop_sequencer
  import seed_seq_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ      = 50000000,
  parameter int unsigned DROP_TIMEOUT_MS = 2000,
  parameter int unsigned SETTLE_CYCLES   = 5000,
  parameter int unsigned MAX_RETRIES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        hole_ready,
  input  logic        abort,
  input  logic        target_reached,
  input  logic        sensor_error,
  output logic        start_counting,
  output logic        stop_counting,
  output logic        meter_motor_on,
  output logic        busy,
  output logic        hole_done,
  output logic        hole_short,
  output logic        hole_aborted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] short_hole_count
);

  localparam logic [31:0] DROP_TIMEOUT_CYCLES = drop_timeout_cycles(CLOCK_FREQ, DROP_TIMEOUT_MS);
  localparam logic [31:0] DROP_M1   = DROP_TIMEOUT_CYCLES - 32'd1;
  localparam logic [31:0] SETTLE_M1 = (SETTLE_CYCLES > 32'd0) ? 32'(SETTLE_CYCLES - 32'd1) : 32'd0;

  seq_state_e state_q, state_d;
  logic       short_q, short_d;
  logic       aborted_q, aborted_d;
  logic       first_q, first_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       motor_q, motor_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       hshort_q, hshort_d;
  logic       habort_q, habort_d;
  logic       fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;
`ifdef SEQ_RETRY_EN
  logic [7:0] retries_q, retries_d;
`endif

  logic        tmr_load;
  logic        tmr_run;
  logic [31:0] tmr_val;
  logic        tmr_expired;

  seq_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .run      (tmr_run),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // Next-state, flag and registered-output decode.
  always_comb begin
    state_d   = state_q;
    short_d   = short_q;
    aborted_d = aborted_q;
    tmr_load  = 1'b0;
    tmr_run   = 1'b0;
    tmr_val   = DROP_M1;
`ifdef SEQ_RETRY_EN
    retries_d = retries_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (hole_ready && enable) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        short_d   = 1'b0;
        aborted_d = 1'b0;
`ifdef SEQ_RETRY_EN
        retries_d = 8'd0;
`endif
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_CLOSE;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = DROP_M1;
          state_d  = ST_METER;
        end
      end
      ST_METER: begin
        tmr_run = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_CLOSE;
        end else if (sensor_error) begin
          state_d = ST_FAULT;
        end else if (target_reached && !first_q) begin
          // The counter still shows the previous hole's target on the
          // first METER cycle, hence the first_q qualifier.
          tmr_load = 1'b1;
          tmr_val  = SETTLE_M1;
          state_d  = ST_SETTLE;
        end else if (tmr_expired) begin
`ifdef SEQ_RETRY_EN
          if (retries_q < 8'(MAX_RETRIES)) begin
            retries_d = retries_q + 8'd1;
            tmr_load  = 1'b1;
            tmr_val   = DROP_M1;
            state_d   = ST_METER;
          end else begin
            short_d  = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_M1;
            state_d  = ST_SETTLE;
          end
`else
          short_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_M1;
          state_d  = ST_SETTLE;
`endif
        end else begin
          state_d = ST_METER;
        end
      end
      ST_SETTLE: begin
        tmr_run = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_CLOSE;
        end else if (sensor_error) begin
          state_d = ST_FAULT;
        end else if (tmr_expired) begin
          state_d = ST_CLOSE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_CLOSE: begin
        if (aborted_q) begin
          aborted_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FAULT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the
    // state register on the following cycle.
    first_d  = (state_q == ST_ARM);
    start_d  = (state_d == ST_ARM);
    stop_d   = (state_d == ST_CLOSE) || ((state_d == ST_FAULT) && (state_q != ST_FAULT));
    motor_d  = (state_d == ST_METER);
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_DONE);
    hshort_d = (state_d == ST_DONE) && short_d;
    habort_d = (state_d == ST_CLOSE) && aborted_d;
    fault_d  = (state_d == ST_FAULT);
    if ((state_d == ST_DONE) && short_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      short_q   <= 1'b0;
      aborted_q <= 1'b0;
      first_q   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      motor_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hshort_q  <= 1'b0;
      habort_q  <= 1'b0;
      fault_q   <= 1'b0;
      cnt_q     <= 16'd0;
`ifdef SEQ_RETRY_EN
      retries_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      short_q   <= short_d;
      aborted_q <= aborted_d;
      first_q   <= first_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      motor_q   <= motor_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hshort_q  <= hshort_d;
      habort_q  <= habort_d;
      fault_q   <= fault_d;
      cnt_q     <= cnt_d;
`ifdef SEQ_RETRY_EN
      retries_q <= retries_d;
`endif
    end
  end

  assign start_counting   = start_q;
  assign stop_counting    = stop_q;
  // abort must cut the motor in the very cycle it is asserted.
  assign meter_motor_on   = motor_q & ~abort;
  assign busy             = busy_q;
  assign hole_done        = done_q;
  assign hole_short       = hshort_q;
  assign hole_aborted     = habort_q;
  assign fault            = fault_q;
  assign state            = state_q;
  assign short_hole_count = cnt_q;

endmodule

// File: tb/tb_seed_drop_sequencer.sv
module tb_seed_drop_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        hole_ready = 1'b0;
  logic        abort = 1'b0;
  logic        target_reached = 1'b0;
  logic        sensor_error = 1'b0;
  logic        start_counting, stop_counting, meter_motor_on, busy;
  logic        hole_done, hole_short, hole_aborted, fault;
  logic [2:0]  state;
  logic [15:0] short_hole_count;

  int n_chk = 0;
  int n_fail = 0;

`ifdef SEQ_RETRY_EN
  localparam int EXP_TMO = 3000;
`else
  localparam int EXP_TMO = 1000;
`endif

  seed_drop_sequencer #(
    .CLOCK_FREQ      (1000000),
    .DROP_TIMEOUT_MS (1),
    .SETTLE_CYCLES   (4),
    .MAX_RETRIES     (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .hole_ready       (hole_ready),
    .abort            (abort),
    .target_reached   (target_reached),
    .sensor_error     (sensor_error),
    .start_counting   (start_counting),
    .stop_counting    (stop_counting),
    .meter_motor_on   (meter_motor_on),
    .busy             (busy),
    .hole_done        (hole_done),
    .hole_short       (hole_short),
    .hole_aborted     (hole_aborted),
    .fault            (fault),
    .state            (state),
    .short_hole_count (short_hole_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en, hr, ab, tr, se;
    logic [10:0] exp;  // {start,stop,motor,busy,done,short,aborted,fault,state[2:0]}
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs shortly after the edge, return mid-cycle.
  task automatic cyc(input logic en, input logic hr, input logic ab, input logic tr, input logic se);
    @(posedge clk);
    #1;
    enable = en; hole_ready = hr; abort = ab; target_reached = tr; sensor_error = se;
    #3;
  endtask

  function automatic logic [10:0] outs();
    return {start_counting, stop_counting, meter_motor_on, busy, hole_done,
            hole_short, hole_aborted, fault, state};
  endfunction

  initial begin
    int motor_cnt, stop_idx, done_idx, done_cnt, ab_idx;
    logic short_at_done, mot9, mot10;

    // Fault path, dropped hole_ready and simultaneous-event abort path.
    tbl[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 11'b0_0_0_0_0_0_0_0_000};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 11'b1_0_0_1_0_0_0_0_001};
    tbl[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 11'b0_0_1_1_0_0_0_0_010};
    tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 11'b0_0_1_1_0_0_0_0_010};
    tbl[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 11'b0_0_0_1_0_0_0_0_011};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 11'b0_0_0_1_0_0_0_0_011};
    tbl[6]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 11'b0_1_0_1_0_0_0_1_110};
    tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 11'b0_0_0_1_0_0_0_1_110};
    tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 11'b0_0_0_0_0_0_0_0_000};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 11'b0_0_0_0_0_0_0_0_000};
    tbl[10] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 11'b1_0_0_1_0_0_0_0_001};
    tbl[11] = '{1'b1,1'b0,1'b1,1'b1,1'b1, 11'b0_0_0_1_0_0_0_0_010};
    tbl[12] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 11'b0_1_0_1_0_0_1_0_100};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 11'b0_0_0_0_0_0_0_0_000};

    // Reset state.
    #23;
    chk("reset_outputs", {21'd0, outs()}, 32'd0);
    chk("reset_count", {16'd0, short_hole_count}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].en, tbl[i].hr, tbl[i].ab, tbl[i].tr, tbl[i].se);
      chk($sformatf("vec%0d", i), {21'd0, outs()}, {21'd0, tbl[i].exp});
    end

    // Normal hole: target 50 cycles into METER.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("normal_start", {31'd0, start_counting}, 32'd1);
    motor_cnt = 0; stop_idx = -1; done_idx = -1; done_cnt = 0; short_at_done = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, 1'b0, (i == 50), 1'b0);
      if (meter_motor_on) motor_cnt++;
      if (stop_counting && stop_idx < 0) stop_idx = i;
      if (hole_done) begin done_idx = i; done_cnt++; short_at_done = hole_short; end
    end
    chk("normal_motor_cycles", motor_cnt, 32'd51);
    chk("normal_stop_idx", stop_idx, 32'd55);
    chk("normal_done_idx", done_idx, 32'd56);
    chk("normal_done_cnt", done_cnt, 32'd1);
    chk("normal_short", {31'd0, short_at_done}, 32'd0);
    chk("normal_count", {16'd0, short_hole_count}, 32'd0);

    // Timeout: no target at all.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    motor_cnt = 0; stop_idx = -1; done_cnt = 0; short_at_done = 1'b0;
    for (int i = 0; i < 3100; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (meter_motor_on) motor_cnt++;
      if (stop_counting && stop_idx < 0) stop_idx = i;
      if (hole_done) begin done_cnt++; short_at_done = hole_short; end
    end
    chk("tmo_motor_cycles", motor_cnt, EXP_TMO);
    chk("tmo_stop_idx", stop_idx, EXP_TMO + 4);
    chk("tmo_done_cnt", done_cnt, 32'd1);
    chk("tmo_short", {31'd0, short_at_done}, 32'd1);
    chk("tmo_count", {16'd0, short_hole_count}, 32'd1);

`ifdef SEQ_RETRY_EN
    // Target during the second attempt gives a full hole.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    motor_cnt = 0; done_cnt = 0; short_at_done = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      cyc(1'b1, 1'b0, 1'b0, (i == 1500), 1'b0);
      if (meter_motor_on) motor_cnt++;
      if (hole_done) begin done_cnt++; short_at_done = hole_short; end
    end
    chk("retry_motor_cycles", motor_cnt, 32'd1501);
    chk("retry_done_cnt", done_cnt, 32'd1);
    chk("retry_short", {31'd0, short_at_done}, 32'd0);
    chk("retry_count", {16'd0, short_hole_count}, 32'd1);
`endif

    // Abort at METER cycle 10.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stop_idx = -1; ab_idx = -1; done_cnt = 0; mot9 = 1'b0; mot10 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, (i == 10), 1'b0, 1'b0);
      if (i == 9) mot9 = meter_motor_on;
      if (i == 10) mot10 = meter_motor_on;
      if (stop_counting && stop_idx < 0) stop_idx = i;
      if (hole_aborted && ab_idx < 0) ab_idx = i;
      if (hole_done) done_cnt++;
    end
    chk("abort_motor_before", {31'd0, mot9}, 32'd1);
    chk("abort_motor_same_cycle", {31'd0, mot10}, 32'd0);
    chk("abort_stop_idx", stop_idx, 32'd11);
    chk("abort_pulse_idx", ab_idx, 32'd11);
    chk("abort_no_done", done_cnt, 32'd0);
    chk("abort_state_idle", {29'd0, state}, 32'd0);

    // Reset in the middle of METER.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_motor_before", {31'd0, meter_motor_on}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {21'd0, outs()}, 32'd0);
    chk("midrst_count", {16'd0, short_hole_count}, 32'd0);
    #2;
    rst_n = 1'b1;
    done_cnt = 0; stop_idx = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (hole_done) done_cnt++;
      if (stop_counting && stop_idx < 0) stop_idx = i;
    end
    chk("midrst_no_done", done_cnt, 32'd0);
    chk("midrst_no_stop", stop_idx, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
